// File: rtl/serial_byte_tx.sv
// ============================================================================
// serial_byte_tx
// ----------------------------------------------------------------------------
// Sending end of a start/data/stop framed serial line. A byte is taken over a
// valid/ready handshake. It is then shifted out one bit per clock as:
//   start (0), 8 data bits (LSB- or MSB-first), optional odd parity,
//   and STOP_BITS stop cycles (1).
// in_ready is also high in the last stop cycle, so frames can run back to
// back with no idle gap.
//
// Parameters:
//   LSB_FIRST  1 = data bit 0 first, 0 = data bit 7 first
//   PARITY_EN  1 = append one odd-parity bit after the data bits
//   STOP_BITS  number of stop-bit cycles, 1..4
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   in_valid  in   in_data holds a byte to send
//   in_data   in   [7:0] byte to transmit
//   in_ready  out  byte can be accepted this cycle (IDLE or last STOP)
//   out       out  registered serial line, idles at 1
//   busy      out  frame in progress (START through last STOP)
//   done      out  one-cycle pulse during the final stop bit
// ============================================================================
module serial_byte_tx #(
    parameter int LSB_FIRST = 1,
    parameter int PARITY_EN = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out,
    output logic       busy,
    output logic       done
);

    if (STOP_BITS < 1 || STOP_BITS > 4) begin : g_bad_stop
        $error("serial_byte_tx: STOP_BITS must be in 1..4");
    end

    localparam logic [1:0] STOP_LAST = 2'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t     r_state;
    logic [7:0] r_shift;
    logic [2:0] r_cnt;
    logic [1:0] r_stop_cnt;
    logic       r_out;
    logic       r_busy;
    logic       r_done;

    logic       w_last_stop;
    logic       w_accept;

    // Bit that goes on the line next, taken from the head of the register.
    function automatic logic head_bit(input logic [7:0] v);
        return (LSB_FIRST != 0) ? v[0] : v[7];
    endfunction

    // Rotate (not shift) so the captured byte is whole again after eight
    // steps; parity is then taken from the original byte at the end of DATA.
    function automatic logic [7:0] rotate(input logic [7:0] v);
        return (LSB_FIRST != 0) ? {v[0], v[7:1]} : {v[6:0], v[7]};
    endfunction

    assign w_last_stop = (r_state == S_STOP) && (r_stop_cnt == STOP_LAST);
    assign in_ready    = (r_state == S_IDLE) || w_last_stop;
    assign w_accept    = in_valid && in_ready;

    assign out  = r_out;
    assign busy = r_busy;
    assign done = r_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shift    <= 8'h00;
            r_cnt      <= 3'd0;
            r_stop_cnt <= 2'd0;
            r_out      <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift <= in_data;
                        r_out   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    r_out   <= head_bit(r_shift);
                    r_shift <= rotate(r_shift);
                    r_cnt   <= 3'd0;
                    r_state <= S_DATA;
                end

                S_DATA: begin
                    if (r_cnt == 3'd7) begin
                        r_cnt <= 3'd0;
                        if (PARITY_EN != 0) begin
                            r_out   <= ~^r_shift;
                            r_state <= S_PARITY;
                        end else begin
                            r_out      <= 1'b1;
                            r_stop_cnt <= 2'd0;
                            r_done     <= (STOP_LAST == 2'd0);
                            r_state    <= S_STOP;
                        end
                    end else begin
                        r_out   <= head_bit(r_shift);
                        r_shift <= rotate(r_shift);
                        r_cnt   <= r_cnt + 3'd1;
                    end
                end

                S_PARITY: begin
                    r_out      <= 1'b1;
                    r_stop_cnt <= 2'd0;
                    r_done     <= (STOP_LAST == 2'd0);
                    r_state    <= S_STOP;
                end

                S_STOP: begin
                    if (r_stop_cnt == STOP_LAST) begin
                        r_done     <= 1'b0;
                        r_stop_cnt <= 2'd0;
                        if (w_accept) begin
                            // Next frame's start bit follows the last stop bit directly.
                            r_shift <= in_data;
                            r_out   <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= S_START;
                        end else begin
                            r_out   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_stop_cnt <= r_stop_cnt + 2'd1;
                        r_done     <= ((r_stop_cnt + 2'd1) == STOP_LAST);
                    end
                end

                default: begin
                    r_out   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_byte_tx.sv
// ============================================================================
// tb_serial_byte_tx
// ----------------------------------------------------------------------------
// Four instances cover the parameter sets in use:
//   0: LSB-first, no parity, 1 stop
//   1: MSB-first, no parity, 1 stop
//   2: LSB-first, parity,    1 stop
//   3: LSB-first, no parity, 2 stop
// One instance is selected at a time. Bytes are queued as stimulus. On each
// accepted byte the expected per-cycle line values (out/busy/done/in_ready)
// are pushed to a scoreboard. They are popped and compared one per cycle.
// When the scoreboard is empty, the idle/reset values are expected.
// ============================================================================
module tb_serial_byte_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       tb_valid;
    logic [7:0] tb_data;
    int         sel;
    int         tnum;

    logic vld [4];
    logic rdy [4];
    logic ln  [4];
    logic bsy [4];
    logic dn  [4];

    always_comb begin
        for (int i = 0; i < 4; i++) vld[i] = tb_valid && (sel == i);
    end

    serial_byte_tx #(.LSB_FIRST(1), .PARITY_EN(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(vld[0]), .in_data(tb_data),
        .in_ready(rdy[0]), .out(ln[0]), .busy(bsy[0]), .done(dn[0]));
    serial_byte_tx #(.LSB_FIRST(0), .PARITY_EN(0), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(vld[1]), .in_data(tb_data),
        .in_ready(rdy[1]), .out(ln[1]), .busy(bsy[1]), .done(dn[1]));
    serial_byte_tx #(.LSB_FIRST(1), .PARITY_EN(1), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(vld[2]), .in_data(tb_data),
        .in_ready(rdy[2]), .out(ln[2]), .busy(bsy[2]), .done(dn[2]));
    serial_byte_tx #(.LSB_FIRST(1), .PARITY_EN(0), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .reset(reset), .in_valid(vld[3]), .in_data(tb_data),
        .in_ready(rdy[3]), .out(ln[3]), .busy(bsy[3]), .done(dn[3]));

    int cfg_lsb  [4] = '{1, 0, 1, 1};
    int cfg_par  [4] = '{0, 0, 1, 0};
    int cfg_stop [4] = '{1, 1, 1, 2};

    typedef struct packed {
        logic o;
        logic b;
        logic d;
        logic r;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] src_q[$];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    function automatic exp_t mk(input logic o, input logic b, input logic d, input logic r);
        exp_t e;
        e.o = o; e.b = b; e.d = d; e.r = r;
        return e;
    endfunction

    // Expected line for one frame of byte b on the selected configuration.
    task automatic push_frame(input logic [7:0] b);
        logic bitv;
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
        for (int n = 0; n < 8; n++) begin
            bitv = (cfg_lsb[sel] != 0) ? b[n] : b[7 - n];
            exp_q.push_back(mk(bitv, 1'b1, 1'b0, 1'b0));
        end
        if (cfg_par[sel] != 0) exp_q.push_back(mk(~^b, 1'b1, 1'b0, 1'b0));
        for (int s = 0; s < cfg_stop[sel]; s++) begin
            exp_q.push_back(mk(1'b1, 1'b1, s == cfg_stop[sel] - 1, s == cfg_stop[sel] - 1));
        end
    endtask

    task automatic drive_inputs();
        tb_valid = (src_q.size() > 0);
        tb_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
    endtask

    // One clock: note whether the coming edge accepts, drive, then compare
    // the DUT on the falling edge against the scoreboard head.
    task automatic cycle();
        logic       acc;
        logic [7:0] byte_now;
        exp_t       e;
        acc      = tb_valid && rdy[sel];
        byte_now = tb_data;
        @(posedge clk);
        if (acc) begin
            push_frame(byte_now);
            void'(src_q.pop_front());
        end
        #1;
        drive_inputs();
        @(negedge clk);
        cyc++;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = mk(1'b1, 1'b0, 1'b0, 1'b1);
        check_val($sformatf("t%0d c%0d out", tnum, cyc), 32'(ln[sel]), 32'(e.o));
        check_val($sformatf("t%0d c%0d busy", tnum, cyc), 32'(bsy[sel]), 32'(e.b));
        check_val($sformatf("t%0d c%0d done", tnum, cyc), 32'(dn[sel]), 32'(e.d));
        check_val($sformatf("t%0d c%0d in_ready", tnum, cyc), 32'(rdy[sel]), 32'(e.r));
    endtask

    task automatic run_drain(input int max_cycles);
        int k;
        k = 0;
        drive_inputs();
        while ((src_q.size() > 0 || exp_q.size() > 0) && k < max_cycles) begin
            cycle();
            k++;
        end
        check_val($sformatf("t%0d drain", tnum), 32'(src_q.size() + exp_q.size()), 32'd0);
        cycle();
        cycle();
    endtask

    initial begin
        reset    = 1'b1;
        sel      = 0;
        tnum     = 0;
        tb_valid = 1'b0;
        tb_data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cycle();                 // reset held: reset values expected
        reset = 1'b0;
        cycle();

        // 1: LSB-first 0x01
        tnum = 1; sel = 0;
        src_q.push_back(8'h01);
        run_drain(100);

        // 2: MSB-first 0x01
        tnum = 2; sel = 1;
        src_q.push_back(8'h01);
        run_drain(100);

        // 3: odd parity
        tnum = 3; sel = 2;
        src_q.push_back(8'h03);
        run_drain(100);
        src_q.push_back(8'h07);
        run_drain(100);

        // 4: back-to-back frames with valid held high
        tnum = 4; sel = 0;
        src_q.push_back(8'hA5);
        src_q.push_back(8'h3C);
        run_drain(100);

        // 5: two stop bits
        tnum = 5; sel = 3;
        src_q.push_back(8'hFF);
        run_drain(100);

        // 6: reset during data bit 4, then a fresh frame
        tnum = 6; sel = 0;
        src_q.push_back(8'h55);
        drive_inputs();
        cycle();                 // accept; start bit on line
        repeat (5) cycle();      // data bits 0..4
        reset = 1'b1;
        exp_q.delete();
        cycle();                 // idle values, no done
        reset = 1'b0;
        cycle();
        src_q.push_back(8'h80);
        run_drain(100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
